// File: rtl/rst_gen.sv
// rst_gen: system reset generator.
//
// Merges the board reset button, PLL lock, a software reset request and a
// watchdog bite into one stretched, glitch-free active-low reset. A sticky
// cause register records which triggers fired on the last RUN->ASSERT entry.
//
// Optional feature macro:
//   RST_GEN_WDT_EN  defined   -> wdt_bite_i is a reset trigger, loads rst_cause_o[3]
//                   undefined -> wdt_bite_i ignored, rst_cause_o[3] stays 0
//
// Parameters:
//   CNT_W        width of the debounce and hold counters
//   DEB_CYCLES   stable samples needed to accept a button level change (>= 2)
//   HOLD_CYCLES  minimum reset assertion length after hold conditions clear (>= 2)
//
// Ports:
//   clk           free-running reference clock
//   arst_i        power-on reset, asynchronous, active-low
//   btn_n_i       raw board reset button, active-low, asynchronous, bouncy
//   pll_locked_i  PLL lock indicator, asynchronous
//   sw_rst_req_i  software reset request, clk domain, single-cycle pulse
//   wdt_bite_i    watchdog expiry, clk domain
//   rst_n_o       registered active-low system reset
//   rst_cause_o   sticky cause: [0] POR/PLL, [1] button, [2] software, [3] watchdog

module rst_gen #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DEB_CYCLES  = 1000,
    parameter int unsigned HOLD_CYCLES = 256
) (
    input  logic       clk,
    input  logic       arst_i,
    input  logic       btn_n_i,
    input  logic       pll_locked_i,
    input  logic       sw_rst_req_i,
    input  logic       wdt_bite_i,
    output logic       rst_n_o,
    output logic [3:0] rst_cause_o
);

    localparam logic [CNT_W-1:0] DebLast  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    typedef enum logic [0:0] {
        StAssert = 1'b0,
        StRun    = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers. Button resets released (1), lock resets lost (0)
    // so a fresh power-up always waits for a real lock indication.
    // ------------------------------------------------------------------
    logic btn_meta_q, btn_s_q;
    logic lock_meta_q, lock_s_q;

    always_ff @(posedge clk or negedge arst_i) begin
        if (!arst_i) begin
            btn_meta_q  <= 1'b1;
            btn_s_q     <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            btn_meta_q  <= btn_n_i;
            btn_s_q     <= btn_meta_q;
            lock_meta_q <= pll_locked_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Button debouncer: a new level is accepted only after DEB_CYCLES
    // consecutive samples that differ from the current debounced level.
    // Any sample matching the current level restarts the count.
    // ------------------------------------------------------------------
    logic             btn_db_q, btn_db_d;
    logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
    logic             press;

    always_comb begin
        btn_db_d  = btn_db_q;
        deb_cnt_d = '0;
        if (btn_s_q != btn_db_q) begin
            if (deb_cnt_q == DebLast) begin
                btn_db_d  = btn_s_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_i) begin
        if (!arst_i) begin
            btn_db_q  <= 1'b1;
            deb_cnt_q <= '0;
        end else begin
            btn_db_q  <= btn_db_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign press = ~btn_db_q;

    // ------------------------------------------------------------------
    // Trigger vector, laid out to match rst_cause_o bit positions.
    // ------------------------------------------------------------------
    logic [3:0] trig;
    logic       any_trig;

    assign trig[0] = ~lock_s_q;
    assign trig[1] = press;
    assign trig[2] = sw_rst_req_i;
`ifdef RST_GEN_WDT_EN
    assign trig[3] = wdt_bite_i;
`else
    assign trig[3] = 1'b0;
    // Port kept for pin compatibility; deliberately unused in this build.
    logic unused_wdt;
    assign unused_wdt = wdt_bite_i;
`endif
    assign any_trig = |trig;

    // ------------------------------------------------------------------
    // Reset FSM. In ASSERT only lock loss and a pressed button matter: they
    // restart the hold count. Software and watchdog requests are dropped
    // since the system is already in reset.
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [3:0]       cause_q, cause_d;
    logic             rst_n_q, rst_n_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cause_d = cause_q;
        case (state_q)
            StAssert: begin
                if (!lock_s_q || press) begin
                    hold_d = '0;
                end else if (hold_q == HoldLast) begin
                    hold_d  = '0;
                    state_d = StRun;
                end else begin
                    hold_d = hold_q + CntOne;
                end
            end
            StRun: begin
                // Counter is kept at zero so ASSERT always starts a full count.
                hold_d = '0;
                if (any_trig) begin
                    state_d = StAssert;
                    cause_d = trig;
                end
            end
            default: begin
                state_d = StAssert;
                hold_d  = '0;
            end
        endcase
        // Output flop tracks the next state so rst_n_o is a pure register.
        rst_n_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge arst_i) begin
        if (!arst_i) begin
            state_q <= StAssert;
            hold_q  <= '0;
            cause_q <= 4'b0001;
            rst_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cause_q <= cause_d;
            rst_n_q <= rst_n_d;
        end
    end

    assign rst_n_o     = rst_n_q;
    assign rst_cause_o = cause_q;

endmodule

// File: tb/tb_rst_gen.sv
// tb_rst_gen: self-checking bench for rst_gen (DEB_CYCLES=4, HOLD_CYCLES=8).
// Expected rst_n_o edges (level, clk edge number, cause) are queued as stimulus
// is driven; a negedge monitor pops one entry per observed rst_n_o transition.

module tb_rst_gen;

    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 8;

`ifdef RST_GEN_WDT_EN
    localparam logic [3:0] SimCause = 4'b1100;
`else
    localparam logic [3:0] SimCause = 4'b0100;
`endif

    logic       clk = 1'b0;
    logic       arst_i;
    logic       btn_n_i;
    logic       pll_locked_i;
    logic       sw_rst_req_i;
    logic       wdt_bite_i;
    logic       rst_n_o;
    logic [3:0] rst_cause_o;

    rst_gen #(
        .CNT_W      (16),
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .arst_i      (arst_i),
        .btn_n_i     (btn_n_i),
        .pll_locked_i(pll_locked_i),
        .sw_rst_req_i(sw_rst_req_i),
        .wdt_bite_i  (wdt_bite_i),
        .rst_n_o     (rst_n_o),
        .rst_cause_o (rst_cause_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    typedef struct {
        string      tag;
        logic       lvl;
        int         edge_no;
        logic [3:0] cause;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic prev_rst = 1'b0;

    task automatic push_exp(input string tag, input logic lvl, input int edge_no,
                            input logic [3:0] cause);
        exp_t e;
        e.tag = tag; e.lvl = lvl; e.edge_no = edge_no; e.cause = cause;
        sb.push_back(e);
    endtask

    // Every rst_n_o transition must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n_o !== prev_rst) begin
            if (sb.size() == 0) begin
                chk("spurious_rst_edge", rst_n_o, prev_rst);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.tag, "_lvl"}, rst_n_o, mon_e.lvl);
                chk({mon_e.tag, "_edge"}, cyc, mon_e.edge_no);
                chk({mon_e.tag, "_cause"}, rst_cause_o, mon_e.cause);
            end
            prev_rst = rst_n_o;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    int c, r, e;

    initial begin
        arst_i = 1'b0; pll_locked_i = 1'b1; btn_n_i = 1'b1;
        sw_rst_req_i = 1'b0; wdt_bite_i = 1'b0;

        // Power-on
        step(5);
        chk("por_rst_n", rst_n_o, 0);
        chk("por_cause", rst_cause_o, 4'b0001);
        c = cyc;
        arst_i = 1'b1;
        push_exp("por_rise", 1'b1, c + 10, 4'b0001);
        wait_drain(40);

        // Software reset: low next edge, exactly HOLD cycles
        c = cyc;
        push_exp("sw_fall", 1'b0, c + 1, 4'b0100);
        push_exp("sw_rise", 1'b1, c + 1 + HOLD, 4'b0100);
        sw_rst_req_i = 1'b1; step(1); sw_rst_req_i = 1'b0;
        wait_drain(40);

        // Bouncy button: never reaches DEB stable samples
        for (int k = 0; k < 5; k++) begin
            btn_n_i = 1'b0; step(3);
            btn_n_i = 1'b1; step(1);
        end
        step(12);
        chk("bounce_no_rst", rst_n_o, 1);
        chk("bounce_cause", rst_cause_o, 4'b0100);

        // Button held 30 cycles
        c = cyc;
        push_exp("btn_fall", 1'b0, c + 2 + DEB + 1, 4'b0010);
        btn_n_i = 1'b0; step(30);
        r = cyc;
        push_exp("btn_rise", 1'b1, r + 2 + DEB + HOLD, 4'b0010);
        btn_n_i = 1'b1;
        wait_drain(60);

        // Simultaneous software + watchdog
        c = cyc;
        push_exp("sim_fall", 1'b0, c + 1, SimCause);
        push_exp("sim_rise", 1'b1, c + 1 + HOLD, SimCause);
        sw_rst_req_i = 1'b1; wdt_bite_i = 1'b1; step(1);
        sw_rst_req_i = 1'b0; wdt_bite_i = 1'b0;
        wait_drain(40);

        // Watchdog alone
        c = cyc;
`ifdef RST_GEN_WDT_EN
        push_exp("wdt_fall", 1'b0, c + 1, 4'b1000);
        push_exp("wdt_rise", 1'b1, c + 1 + HOLD, 4'b1000);
`endif
        wdt_bite_i = 1'b1; step(1); wdt_bite_i = 1'b0;
        step(12);
        wait_drain(40);
        chk("wdt_done_rst_n", rst_n_o, 1);

        // Lock loss at hold count 5, relock 10 cycles later
        c = cyc;
        push_exp("lmh_fall", 1'b0, c + 1, 4'b0100);
        sw_rst_req_i = 1'b1; step(1); sw_rst_req_i = 1'b0;
        step(5);
        pll_locked_i = 1'b0; step(10);
        e = cyc;
        push_exp("lmh_rise", 1'b1, e + 2 + HOLD, 4'b0100);
        pll_locked_i = 1'b1;
        wait_drain(40);

        // Lock loss in RUN
        c = cyc;
        push_exp("pll_fall", 1'b0, c + 3, 4'b0001);
        pll_locked_i = 1'b0; step(5);
        e = cyc;
        push_exp("pll_rise", 1'b1, e + 2 + HOLD, 4'b0001);
        pll_locked_i = 1'b1;
        wait_drain(40);

        // Re-arm cause to software before the async test
        c = cyc;
        push_exp("sw2_fall", 1'b0, c + 1, 4'b0100);
        push_exp("sw2_rise", 1'b1, c + 1 + HOLD, 4'b0100);
        sw_rst_req_i = 1'b1; step(1); sw_rst_req_i = 1'b0;
        wait_drain(40);

        // Async reset pulse between edges
        c = cyc;
        push_exp("arst_fall", 1'b0, c, 4'b0001);
        arst_i = 1'b0;
        #1;
        chk("arst_rst_n_now", rst_n_o, 0);
        chk("arst_cause_now", rst_cause_o, 4'b0001);
        arst_i = 1'b1;
        push_exp("arst_rise", 1'b1, c + 10, 4'b0001);
        wait_drain(40);

        step(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
